pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: CLK is the single clock, and RST is sampled only on the rising edge of CLK.
REQ-002 SHALL provide these ports (name, dir, width, meaning):
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- mem_req  in  1  EX/MEM stage holds a load or store
- idex_memread  in  1  ID/EX stage holds a load
- idex_rd  in  5  destination register of the ID/EX load
- ifid_rs  in  5  rs field of the IF/ID instruction
- ifid_rt  in  5  rt field of the IF/ID instruction
- branch_taken  in  1  branch resolved taken in EX/MEM
- jump_id  in  1  jump decoded in ID
- halt_mem  in  1  halt instruction reached EX/MEM
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  latch/PC update enables
- ifid_flush, idex_flush  out  1  load zeros into the latch on its enable
- dmem_gate  out  1  allow data request to memory
- halt_out  out  1  processor halted
- stall_cnt, flush_cnt  out  32  performance counters

Function
REQ-003 SHALL implement a state register with states RUN, DWAIT, DDONE, HALT.
REQ-004 SHALL use outputs that are combinational in the current state and the inputs.
REQ-005 SHALL make these state transitions:
- RUN→HALT on halt_mem & ihit
- RUN→DWAIT on mem_req & !dhit
- RUN→DDONE on mem_req & dhit & !ihit
- DWAIT→DDONE on dhit
- DDONE→RUN on ihit
- HALT is sticky until RST
REQ-006 SHALL define adv = ihit & ((state==RUN & !mem_req) | (state==RUN & mem_req & dhit) | state==DDONE).
REQ-007 SHALL drive exmem_en = adv and idex_en = adv.
REQ-008 SHALL drive memwb_en = adv | (dhit & state!=HALT), so load data is captured on dhit even when ihit is low.
REQ-009 SHALL drive dmem_gate = 1 in RUN and DWAIT, and 0 in DDONE and HALT; a completed access is never reissued.
REQ-010 SHALL set lu = idex_memread & (idex_rd!=0) & (idex_rd==ifid_rs | idex_rd==ifid_rt).
REQ-011 SHALL, on load-use (adv & lu & !branch_taken), drive pc_en=0, ifid_en=0, idex_flush=1, i.e. insert one bubble.
REQ-012 SHALL otherwise drive pc_en = ifid_en = adv.
REQ-013 SHALL, on adv & branch_taken, drive ifid_flush=1, idex_flush=1 and pc_en=1; branch flush overrides load-use.
REQ-014 SHALL, on adv & jump_id & !branch_taken, drive ifid_flush=1; jump_id with lu yields the stall only, and the jump is re-evaluated next cycle.
REQ-015 SHALL drive flush outputs to 0 whenever adv=0.
REQ-016 SHALL drive all enables and flushes to 0 in HALT, and drive halt_out = (state==HALT).
REQ-017 SHALL give halt_mem & mem_req in the same cycle halt priority, with dmem_gate forced to 0.
REQ-018 SHALL produce stall/flush outputs in the same cycle as their cause (zero latency); a load-use bubble lasts exactly one adv cycle.

Reset
REQ-019 SHALL, with RST=1 at a CLK edge, set state=RUN and stall_cnt=flush_cnt=0.
REQ-020 SHALL, while RST=1, force all enables, flushes, dmem_gate and halt_out to 0.
REQ-021 SHALL abandon the access when reset is asserted in DWAIT, DDONE or HALT, and return to RUN on the edge after RST deasserts.

Configuration
REQ-022 SHALL support macro PIPE_PERF_CNT_EN as follows:
- defined: stall_cnt increments on each non-reset cycle with state!=HALT and adv=0.
- defined: flush_cnt increments on each cycle with ifid_flush|idex_flush.
- both counters saturate at 32'hFFFFFFFF.
- undefined: the counters are not built, and stall_cnt and flush_cnt are tied to 0.

Verification
REQ-023 SHALL cover: RST=1 for 2 cycles with random inputs → all outputs 0, then RUN with pc_en=ihit.
REQ-024 SHALL cover: idex_memread=1, idex_rd=5, ifid_rt=5, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle.
REQ-025 SHALL cover: mem_req=1 with dhit held low 4 cycles then high while ihit=0, then ihit=1 → DWAIT for 4 cycles, then memwb_en=1 on dhit, then DDONE with dmem_gate=0, and all enables=1 on ihit.
REQ-026 SHALL cover: branch_taken=1 with lu=1 and jump_id=1 → ifid_flush=1, idex_flush=1, pc_en=1.
REQ-027 SHALL cover: halt_mem=1, ihit=1 → halt_out=1 on the next cycle, with enables 0 for 10 cycles regardless of inputs.
REQ-028 SHALL cover, with PIPE_PERF_CNT_EN defined: 3 ihit=0 cycles plus 1 branch flush → stall_cnt=3, flush_cnt=1; undefined → both 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and stall controller for a 5-stage in-order pipeline.
//
// Tracks the state of the single outstanding data access (RUN, DWAIT, DDONE,
// HALT) and produces the latch enables, flushes and data-memory gate that
// keep the pipeline coherent across instruction/data memory latency,
// load-use hazards, taken branches, jumps and halt.
//
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   ihit, dhit                      instruction / data access completes this cycle
//   mem_req                         EX/MEM stage holds a load or store
//   idex_memread, idex_rd           ID/EX load and its destination register
//   ifid_rs, ifid_rt                source registers of the IF/ID instruction
//   branch_taken, jump_id, halt_mem control-flow events
//   pc_en, ifid_en, idex_en,
//   exmem_en, memwb_en              PC update and pipeline latch enables
//   ifid_flush, idex_flush          load a bubble into the latch on its enable
//   dmem_gate                       allow the data request to reach memory
//   halt_out                        processor halted
//   stall_cnt, flush_cnt            performance counters
//
// Build option: define PIPE_PERF_CNT_EN to build the saturating stall/flush
// counters; without it both counter outputs are tied to zero.
//
// All control outputs are combinational in the current state and inputs so
// that stalls and flushes take effect in the same cycle as their cause.

module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_req,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        branch_taken,
    input  logic        jump_id,
    input  logic        halt_mem,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        dmem_gate,
    output logic        halt_out,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        DDONE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   adv;
    logic   lu;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                // A halt in EX/MEM wins over its own memory access: the
                // access is never started, we just wait for ihit to retire.
                if (halt_mem) begin
                    if (ihit) state_d = HALT;
                end else if (mem_req && !dhit) begin
                    state_d = DWAIT;
                end else if (mem_req && dhit && !ihit) begin
                    state_d = DDONE;
                end
            end
            DWAIT:   if (dhit) state_d = DDONE;
            DDONE:   if (ihit) state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Advance and hazard detection
    // ------------------------------------------------------------------
    // The whole pipeline advances only when the fetch completes and any
    // data access in EX/MEM is finished (either this cycle or earlier).
    assign adv = ihit & (((state_q == RUN) & !mem_req) |
                         ((state_q == RUN) & mem_req & dhit) |
                         (state_q == DDONE));

    // Register 0 is hardwired, so a load to it never creates a hazard.
    assign lu = idex_memread & (idex_rd != 5'd0) &
                ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

    // ------------------------------------------------------------------
    // Control outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        dmem_gate  = 1'b0;
        halt_out   = 1'b0;

        if (!RST) begin
            halt_out = (state_q == HALT);
            idex_en  = adv;
            exmem_en = adv;
            // Load data is captured as soon as it arrives, even while the
            // fetch side is still stalled.
            memwb_en = adv | (dhit & (state_q != HALT));

            // Once the data access has completed (DDONE) it must not be
            // reissued; a halting instruction never issues its access.
            dmem_gate = ((state_q == RUN) & !(halt_mem & mem_req)) |
                        (state_q == DWAIT);

            if (adv) begin
                if (branch_taken) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed;
                    // this overrides any load-use stall on the wrong path.
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    // Hold PC and IF/ID, inject a bubble into ID/EX. A jump
                    // in ID is left alone and re-evaluated next cycle.
                    idex_flush = 1'b1;
                end else begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = jump_id;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if ((state_q != HALT) && !adv && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((ifid_flush || idex_flush) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
